// File: rtl/sr_pkg.sv
// Shared Q14 constants, controller phase codes and the leaky-integrator step
// used by the SR ignition trigger path.
package sr_pkg;

    localparam int Q14_ONE  = 16384;
    localparam int Q14_ZERO = 0;

    typedef enum logic [1:0] {
        PH_IDLE       = 2'd0,
        PH_ARMED      = 2'd1,
        PH_IGNITE     = 2'd2,
        PH_REFRACTORY = 2'd3
    } sr_phase_e;

    // One leaky-integrator update; >>> on a signed int floors toward -inf.
    function automatic int leaky_step(input int state, input int target, input int shift);
        return state + ((target - state) >>> shift);
    endfunction

endpackage

// File: rtl/sr_leaky_integrator.sv
// First-order leaky integrator: state moves 1/2^SHIFT of the way to target
// on every clk_en sample.
module sr_leaky_integrator
    import sr_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] target,
    output logic signed [WIDTH-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (clk_en) begin
            state <= WIDTH'(leaky_step(int'(state), int'(target), SHIFT));
        end
    end

endmodule

// File: rtl/sr_ignition_trigger.sv
// Trigger generator for the ignition controller: phase coherence, beta
// quiescence with hysteresis, warmup gating and ignition event readback.
module sr_ignition_trigger
    import sr_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int FRAC       = 14,
    parameter int COH_SHIFT  = 6,
    parameter int BETA_SHIFT = 5,
    parameter int QUIET_HOLD = 200,
    parameter int WARMUP     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] sr_in,
    input  logic signed [WIDTH-1:0] ref_in,
    input  logic signed [WIDTH-1:0] beta_in,
    input  logic signed [WIDTH-1:0] quiet_lo,
    input  logic signed [WIDTH-1:0] quiet_hi,
    input  logic                    ignition_active,
    output logic signed [WIDTH-1:0] coherence_out,
    output logic                    beta_quiet,
    output logic signed [WIDTH-1:0] peak_coherence,
    output logic [7:0]              event_count,
    output logic                    warm
);

    localparam logic signed [WIDTH-1:0] COH_ONE  = WIDTH'((FRAC == 14) ? Q14_ONE : (1 << FRAC));
    localparam logic signed [WIDTH-1:0] COH_ZERO = WIDTH'(Q14_ZERO);
    localparam logic signed [WIDTH-1:0] S_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [16:0]             HOLD_MAX = 17'(QUIET_HOLD);
    localparam logic [16:0]             WARM_MAX = 17'(WARMUP);

    logic                    agree;
    logic signed [WIDTH-1:0] coh_target;
    logic signed [WIDTH-1:0] babs;
    logic signed [WIDTH-1:0] coh;
    logic signed [WIDTH-1:0] coh_next;
    logic signed [WIDTH-1:0] coh_out_next;
    logic signed [WIDTH-1:0] env_q;
    logic [15:0]             hold_cnt;
    logic [15:0]             hold_next;
    logic [16:0]             hold_inc;
    logic                    quiet;
    logic                    quiet_next;
    logic [15:0]             warm_cnt;
    logic [16:0]             warm_inc;
    logic                    warm_next;
    logic                    active_d;
    logic                    rise;

    sr_leaky_integrator #(.WIDTH(WIDTH), .SHIFT(COH_SHIFT)) u_coh (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .target (coh_target),
        .state  (coh)
    );

    sr_leaky_integrator #(.WIDTH(WIDTH), .SHIFT(BETA_SHIFT)) u_env (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .target (babs),
        .state  (env_q)
    );

    always_comb begin
        // A zero sample is treated as positive.
        agree      = (sr_in < COH_ZERO) == (ref_in < COH_ZERO);
        coh_target = agree ? COH_ONE : COH_ZERO;

        if (beta_in == S_MIN) begin
            babs = S_MAX;
        end else if (beta_in < COH_ZERO) begin
            babs = -beta_in;
        end else begin
            babs = beta_in;
        end

        // Same step the coherence integrator takes this sample; output and
        // peak must see the post-update value with one sample of latency.
        coh_next = WIDTH'(leaky_step(int'(coh), int'(coh_target), COH_SHIFT));

        hold_inc   = {1'b0, hold_cnt} + 17'd1;
        hold_next  = hold_cnt;
        quiet_next = quiet;
        if (env_q >= quiet_hi) begin
            hold_next  = '0;
            quiet_next = 1'b0;
        end else if (env_q < quiet_lo) begin
            if (hold_inc >= HOLD_MAX) begin
                hold_next  = HOLD_MAX[15:0];
                quiet_next = 1'b1;
            end else begin
                hold_next = hold_inc[15:0];
            end
        end

        warm_inc     = {1'b0, warm_cnt} + 17'd1;
        warm_next    = (warm_inc >= WARM_MAX);
        coh_out_next = warm_next ? coh_next : '0;
        rise         = ignition_active & ~active_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt       <= '0;
            quiet          <= 1'b0;
            warm_cnt       <= '0;
            warm           <= 1'b0;
            coherence_out  <= '0;
            beta_quiet     <= 1'b0;
            active_d       <= 1'b0;
            peak_coherence <= '0;
            event_count    <= '0;
        end else if (clk_en) begin
            hold_cnt <= hold_next;
            quiet    <= quiet_next;
            if (warm_cnt != WARM_MAX[15:0]) begin
                warm_cnt <= warm_inc[15:0];
            end
            warm          <= warm_next;
            coherence_out <= coh_out_next;
            beta_quiet    <= warm_next & quiet_next;
            active_d      <= ignition_active;
            if (rise) begin
                peak_coherence <= coh_out_next;
                if (event_count != 8'hFF) begin
                    event_count <= event_count + 8'd1;
                end
            end else if (ignition_active && (coh_out_next > peak_coherence)) begin
                peak_coherence <= coh_out_next;
            end
        end
    end

endmodule

// File: tb/tb_sr_ignition_trigger.sv
// Bench for sr_ignition_trigger: directed scenarios plus a randomized phase,
// all checked every clock against a sample-level arithmetic model.
module tb_sr_ignition_trigger;

    localparam int W = 18;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clk_en = 1'b0;
    logic signed [W-1:0] sr_in = '0;
    logic signed [W-1:0] ref_in = '0;
    logic signed [W-1:0] beta_in = '0;
    logic signed [W-1:0] quiet_lo = 18'sd800;
    logic signed [W-1:0] quiet_hi = 18'sd1600;
    logic                ignition_active = 1'b0;
    logic signed [W-1:0] coherence_out;
    logic                beta_quiet;
    logic signed [W-1:0] peak_coherence;
    logic [7:0]          event_count;
    logic                warm;

    sr_ignition_trigger dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .sr_in           (sr_in),
        .ref_in          (ref_in),
        .beta_in         (beta_in),
        .quiet_lo        (quiet_lo),
        .quiet_hi        (quiet_hi),
        .ignition_active (ignition_active),
        .coherence_out   (coherence_out),
        .beta_quiet      (beta_quiet),
        .peak_coherence  (peak_coherence),
        .event_count     (event_count),
        .warm            (warm)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard counters ----------------
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_ge(input string name, input longint act, input longint bound);
        total_cnt++;
        if (act >= bound) pass_cnt++;
        else $display("FAIL %s: got %0d, expected >= %0d", name, act, bound);
    endtask

    task automatic chk_le(input string name, input longint act, input longint bound);
        total_cnt++;
        if (act <= bound) pass_cnt++;
        else $display("FAIL %s: got %0d, expected <= %0d", name, act, bound);
    endtask

    // ---------------- behavioural model (one step per sample) ----------------
    int m_coh, m_env, m_envq, m_hold, m_wcnt, m_out, m_peak, m_cnt, n_samp;
    bit m_quiet, m_warm, m_bq, m_act_d;

    function automatic int floor_shift(input int d, input int s);
        int p;
        p = 1 << s;
        if (d >= 0) return d / p;
        return -((-d + p - 1) / p);
    endfunction

    task automatic model_reset();
        m_coh = 0; m_env = 0; m_envq = 0; m_hold = 0; m_wcnt = 0;
        m_out = 0; m_peak = 0; m_cnt = 0; n_samp = 0;
        m_quiet = 0; m_warm = 0; m_bq = 0; m_act_d = 0;
    endtask

    task automatic model_sample();
        int s, r, b, tgt, babs, lo, hi;
        s = sr_in; r = ref_in; b = beta_in; lo = quiet_lo; hi = quiet_hi;
        tgt = ((s >= 0) == (r >= 0)) ? 16384 : 0;
        babs = (b < 0) ? -b : b;
        if (babs > 131071) babs = 131071;
        m_envq = m_env;
        m_coh = m_coh + floor_shift(tgt - m_coh, 6);
        m_env = m_env + floor_shift(babs - m_env, 5);
        if (m_envq >= hi) begin
            m_hold = 0; m_quiet = 0;
        end else if (m_envq < lo) begin
            m_hold = (m_hold + 1 > 200) ? 200 : m_hold + 1;
            if (m_hold == 200) m_quiet = 1;
        end
        if (m_wcnt < 64) m_wcnt++;
        m_warm = (m_wcnt >= 64);
        m_out = m_warm ? m_coh : 0;
        m_bq = m_warm & m_quiet;
        if (ignition_active && !m_act_d) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_peak = m_out;
        end else if (ignition_active && m_out > m_peak) begin
            m_peak = m_out;
        end
        m_act_d = ignition_active;
        n_samp++;
    endtask

    logic [45:0] exp_q[$];
    logic [45:0] e;

    function automatic logic [45:0] pack_exp();
        return {18'(m_out), m_bq, 18'(m_peak), 8'(m_cnt), m_warm};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("coherence_out", coherence_out, $signed(e[45:28]));
            chk("beta_quiet", beta_quiet, e[27]);
            chk("peak_coherence", peak_coherence, $signed(e[26:9]));
            chk("event_count", event_count, e[8:1]);
            chk("warm", warm, e[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input bit en);
        clk_en = en;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (en) model_sample();
        exp_q.push_back(pack_exp());
        clk_en = 1'b0;
    endtask

    // One strobed sample followed by nine idle clocks carrying junk inputs.
    task automatic sample(input int sr, input int rf, input int beta, input bit act);
        sr_in = W'(sr); ref_in = W'(rf); beta_in = W'(beta); ignition_active = act;
        tick(1'b1);
        repeat (9) begin
            sr_in = W'($urandom); ref_in = W'($urandom); beta_in = W'($urandom);
            ignition_active = 1'($urandom);
            tick(1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    int prev_out, first_lo, mode, left, p_agree, sr_v, rf_v, beta_v, mag, sgn;
    bit mono, cancelled, act_r, same;
    logic signed [W-1:0] t;

    initial begin
        model_reset();
        rst = 1'b1;
        tick(1'b0);
        tick(1'b1);
        rst = 1'b0;
        chk("reset_coherence", coherence_out, 0);
        chk("reset_warm", warm, 0);
        chk("reset_count", event_count, 0);

        // Warmup, in-phase coherence and quiet assertion from a silent beta.
        for (int i = 1; i <= 1000; i++) begin
            sample(5000, 5000, 0, 1'b0);
            if (i == 1) chk("model_first_coh", m_coh, 256);
            if (i == 63) begin
                chk("warm_at_63", warm, 0);
                chk("coh_at_63", coherence_out, 0);
            end
            if (i == 64) begin
                chk("warm_at_64", warm, 1);
                chk_ge("coh_at_64", coherence_out, 1);
            end
            if (i == 199) chk("quiet_at_199", beta_quiet, 0);
            if (i == 200) chk("quiet_at_200", beta_quiet, 1);
        end
        chk_ge("coh_settled_high", coherence_out, 16321);

        // Anti-phase decay.
        mono = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            prev_out = m_out;
            sample(5000, -5000, 0, 1'b0);
            if (m_out > prev_out) mono = 1'b0;
        end
        chk("model_antiphase_monotonic", mono, 1);
        chk_le("coh_settled_low", coherence_out, 63);
        chk("quiet_kept_antiphase", beta_quiet, 1);

        // Loud alternating beta cancels quiet on the first env_q >= 1600.
        cancelled = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            sample(5000, 5000, (i % 2) ? 8000 : -8000, 1'b0);
            if (!cancelled) begin
                if (m_envq >= 1600) begin
                    cancelled = 1'b1;
                    chk("quiet_cancel", beta_quiet, 0);
                    chk("model_hold_cleared", m_hold, 0);
                end else begin
                    chk("quiet_before_cancel", beta_quiet, 1);
                end
            end
        end
        chk("cancel_seen", cancelled, 1);

        // Hysteresis band, then re-assertion after 200 quiet samples.
        repeat (300) sample(5000, 5000, 1200, 1'b0);
        chk_ge("model_env_band_lo", m_env, 800);
        chk_le("model_env_band_hi", m_env, 1599);
        repeat (500) sample(5000, 5000, 1200, 1'b0);
        chk("quiet_held_in_band", beta_quiet, 0);
        first_lo = -1;
        for (int i = 1; i <= 400; i++) begin
            sample(5000, 5000, 0, 1'b0);
            if (first_lo < 0 && m_envq < 800) first_lo = n_samp;
            if (first_lo >= 0 && n_samp == first_lo + 198) chk("requiet_at_199th", beta_quiet, 0);
            if (first_lo >= 0 && n_samp == first_lo + 199) chk("requiet_at_200th", beta_quiet, 1);
        end
        chk_ge("requiet_found", first_lo, 1);

        // Readback: three long pulses, then saturation.
        for (int p = 0; p < 3; p++) begin
            repeat (100) sample(5000, 5000, 0, 1'b1);
            repeat (50) sample(5000, 5000, 0, 1'b0);
        end
        chk("count_three", event_count, 3);
        chk_ge("peak_high", peak_coherence, 16321);
        for (int p = 0; p < 300; p++) begin
            sample(5000, 5000, 0, 1'b1);
            sample(5000, 5000, 0, 1'b0);
        end
        chk("count_saturated", event_count, 255);

        // Reset mid-event abandons everything and restarts warmup.
        repeat (5) sample(5000, 5000, 0, 1'b1);
        chk("quiet_before_reset", beta_quiet, 1);
        rst = 1'b1;
        ignition_active = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        chk("midreset_coh", coherence_out, 0);
        chk("midreset_quiet", beta_quiet, 0);
        chk("midreset_peak", peak_coherence, 0);
        chk("midreset_count", event_count, 0);
        chk("midreset_warm", warm, 0);
        for (int i = 1; i <= 70; i++) begin
            sample(5000, 5000, 0, 1'b1);
            if (i == 63) chk("rewarm_at_63", warm, 0);
            if (i == 64) chk("rewarm_at_64", warm, 1);
        end
        chk("count_after_reset", event_count, 1);

        // Randomized phase with block-wise beta regimes and coherence bias.
        left = 0; mode = 0; p_agree = 50; act_r = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (left == 0) begin
                mode = $urandom_range(0, 3);
                left = $urandom_range(30, 300);
                p_agree = $urandom_range(0, 100);
            end
            left--;
            t = W'($urandom);
            sr_v = ($urandom_range(0, 15) == 0) ? 0 : int'(t);
            mag = $urandom_range(0, 131071);
            same = ($urandom_range(0, 99) < p_agree);
            rf_v = ((sr_v < 0) == same) ? -mag - 1 : mag;
            sgn = ($urandom_range(0, 1) == 1) ? -1 : 1;
            case (mode)
                0: beta_v = sgn * int'($urandom_range(0, 700));
                1: beta_v = sgn * int'($urandom_range(700, 1800));
                2: begin t = W'($urandom); beta_v = int'(t); end
                default: beta_v = ($urandom_range(0, 1) == 1) ? -131072 : 131071;
            endcase
            if ($urandom_range(0, 14) == 0) act_r = ~act_r;
            sample(sr_v, rf_v, beta_v, act_r);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
